// File: rtl/block_dispatcher.sv
// block_dispatcher: kernel block scheduler between launch control and the compute cores.
// A kernel of thread_count threads is cut into ceil(thread_count/THREADS_PER_BLOCK) blocks.
// At most one block per cycle is handed to a free core. The search for a free core is
// round-robin from rr_ptr. Completion is then tracked until every core has reported back.
//
// Ports
//   clk, reset          clock; asynchronous active-low reset
//   start               kernel launch (level, sampled in IDLE)
//   abort               cancel the running kernel (ignored in IDLE)
//   thread_count        total threads, latched at launch
//   core_done           per-core block-complete pulse
//   core_start          per-core one-cycle start pulse
//   core_reset          per-core active-high reset: high out of reset, and for one cycle on abort
//   core_block_id       flattened block id per core (core i at [i*COUNT_W +: COUNT_W])
//   core_thread_count   flattened thread count per core (core i at [i*TPB_W +: TPB_W])
//   blocks_issued       blocks issued for the current kernel
//   busy, done          kernel status

// Per-core slot: start pulse, busy flag and the block descriptor last issued to it.
module block_dispatcher_core #(
  parameter int ID_W  = 16,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             flush,
  input  logic             core_done,
  input  logic [ID_W-1:0]  id_in,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             start_pulse,
  output logic             busy,
  output logic [ID_W-1:0]  block_id,
  output logic [CNT_W-1:0] thread_cnt
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_pulse <= 1'b0;
      busy        <= 1'b0;
      block_id    <= '0;
      thread_cnt  <= '0;
    end else begin
      start_pulse <= issue;
      // An issue only ever targets an idle core, so issue and core_done never meet on a busy slot.
      if (flush)          busy <= 1'b0;
      else if (issue)     busy <= 1'b1;
      else if (core_done) busy <= 1'b0;
      if (issue) begin
        block_id   <= id_in;
        thread_cnt <= cnt_in;
      end
    end
  end
endmodule

module block_dispatcher #(
  parameter int NUM_CORES         = 4,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int COUNT_W           = 16,
  // Derived value: leave this at its default.
  parameter int TPB_W             = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic [COUNT_W-1:0]           thread_count,
  input  logic [NUM_CORES-1:0]         core_done,
  output logic [NUM_CORES-1:0]         core_start,
  output logic [NUM_CORES-1:0]         core_reset,
  output logic [NUM_CORES*COUNT_W-1:0] core_block_id,
  output logic [NUM_CORES*TPB_W-1:0]   core_thread_count,
  output logic [COUNT_W-1:0]           blocks_issued,
  output logic                         busy,
  output logic                         done
);
  localparam int LOG_TPB = $clog2(THREADS_PER_BLOCK);
  localparam int PTR_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int WIDE_W  = COUNT_W + LOG_TPB + 1;

  generate
    if (THREADS_PER_BLOCK < 1 || (THREADS_PER_BLOCK & (THREADS_PER_BLOCK - 1)) != 0) begin : g_bad_tpb
      $error("THREADS_PER_BLOCK must be a power of two");
    end
    if (NUM_CORES < 1 || NUM_CORES > 32) begin : g_bad_nc
      $error("NUM_CORES must be in 1..32");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t                             state, state_n;
  logic [COUNT_W-1:0]                 tc;
  logic [COUNT_W:0]                   nb, nb_calc;
  logic [COUNT_W-1:0]                 next_id;
  logic [PTR_W-1:0]                   rr_ptr, pick;
  logic                               found, flush, last_blk;
  logic [NUM_CORES-1:0]               core_busy, issue_vec;
  logic [WIDE_W-1:0]                  remaining;
  logic [TPB_W-1:0]                   issue_cnt;
  logic [NUM_CORES-1:0][COUNT_W-1:0]  slot_id;
  logic [NUM_CORES-1:0][TPB_W-1:0]    slot_cnt;
  int                                 srch_idx;

  // Block count uses one extra bit so thread_count near full scale cannot wrap.
  assign nb_calc  = ({1'b0, thread_count} + (COUNT_W+1)'(THREADS_PER_BLOCK - 1)) >> LOG_TPB;
  assign flush    = abort && (state != S_IDLE);
  assign last_blk = ({1'b0, next_id} == (nb - (COUNT_W+1)'(1)));

  // Threads left from the next block onward; a full block unless this is a short tail.
  assign remaining = WIDE_W'(tc) - (WIDE_W'(next_id) << LOG_TPB);
  assign issue_cnt = (remaining >= WIDE_W'(THREADS_PER_BLOCK)) ? TPB_W'(THREADS_PER_BLOCK)
                                                                : remaining[TPB_W-1:0];

  // First idle core at or after rr_ptr, with wrap. Uses the registered busy flags,
  // so a core freed this cycle is only seen on the next one.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    srch_idx = 0;
    for (int j = 0; j < NUM_CORES; j++) begin
      srch_idx = int'(rr_ptr) + j;
      if (srch_idx >= NUM_CORES) srch_idx = srch_idx - NUM_CORES;
      if (!found && !core_busy[PTR_W'(srch_idx)]) begin
        found = 1'b1;
        pick  = PTR_W'(srch_idx);
      end
    end
  end

  always_comb begin
    issue_vec = '0;
    if (state == S_DISPATCH && found && !flush) issue_vec[pick] = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (start) state_n = (thread_count == '0) ? S_DONE : S_DISPATCH;
      S_DISPATCH: if (found && last_blk) state_n = S_DRAIN;
      S_DRAIN:    if (core_busy == '0) state_n = S_DONE;
      S_DONE:     if (!start) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    if (flush) state_n = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      tc            <= '0;
      nb            <= '0;
      next_id       <= '0;
      rr_ptr        <= '0;
      blocks_issued <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      core_reset    <= '1;
    end else begin
      state      <= state_n;
      core_reset <= {NUM_CORES{flush}};
      busy       <= (state_n == S_DISPATCH) || (state_n == S_DRAIN);
      // done follows the DONE state one edge late. It stays up while start is held.
      // If start is already low, done is a single-cycle pulse.
      done       <= !flush && (state == S_DONE) && (start || !done);
      if (state == S_IDLE && start) begin
        tc            <= thread_count;
        nb            <= nb_calc;
        next_id       <= '0;
        blocks_issued <= '0;
      end
      if (issue_vec != '0) begin
        next_id       <= next_id + COUNT_W'(1);
        blocks_issued <= blocks_issued + COUNT_W'(1);
        rr_ptr        <= (pick == PTR_W'(NUM_CORES - 1)) ? '0 : pick + PTR_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    block_dispatcher_core #(
      .ID_W  (COUNT_W),
      .CNT_W (TPB_W)
    ) u_core (
      .clk         (clk),
      .reset       (reset),
      .issue       (issue_vec[i]),
      .flush       (flush),
      .core_done   (core_done[i]),
      .id_in       (next_id),
      .cnt_in      (issue_cnt),
      .start_pulse (core_start[i]),
      .busy        (core_busy[i]),
      .block_id    (slot_id[i]),
      .thread_cnt  (slot_cnt[i])
    );
  end

  assign core_block_id     = slot_id;
  assign core_thread_count = slot_cnt;
endmodule
